// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and counter sizing for the bit-serial subtractor.
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor cell computing x - y - bin.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial unsigned subtractor with start/busy/done handshake.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    import serial_sub_pkg::*;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_next;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic br, d, bout, last;
    full_sub u_fs (.x(sa[0]), .y(sb[0]), .bin(br), .d(d), .bout(bout));
    assign last = cnt == LAST;
    always_comb begin
        state_next = (state == IDLE) ? (start ? RUN : IDLE) :
                     (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy = state != IDLE;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa <= '0;
            sb <= '0;
            br <= 1'b0;
            cnt <= '0;
            diff <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                sa <= a;
                sb <= b;
                br <= 1'b0;
                cnt <= '0;
                diff <= '0;
                borrow <= 1'b0;
            end else if (state == RUN) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                br <= bout;
                diff <= {d, diff[WIDTH-1:1]};
                cnt <= last ? '0 : cnt + 1'b1;
                // borrow is published only once the final bit is processed
                if (last) borrow <= bout;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=4.
module tb_serial_sub;
    logic clk, rst;
    logic start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic start4, busy4, done4, borrow4;
    logic [3:0] a4, b4, diff4;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] e8;
    logic [4:0] e4;
    int checks = 0;
    int failures = 0;

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );
    serial_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL sb8 unexpected done: diff=%h borrow=%b", diff8, borrow8);
            end else begin
                e8 = q8.pop_front();
                if ({diff8, borrow8} !== e8) begin
                    failures++;
                    $display("FAIL sb8 result: got diff=%h borrow=%b, want diff=%h borrow=%b",
                             diff8, borrow8, e8[8:1], e8[0]);
                end
            end
        end
        if (done4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL sb4 unexpected done: diff=%h borrow=%b", diff4, borrow4);
            end else begin
                e4 = q4.pop_front();
                if ({diff4, borrow4} !== e4) begin
                    failures++;
                    $display("FAIL sb4 result: got diff=%h borrow=%b, want diff=%h borrow=%b",
                             diff4, borrow4, e4[4:1], e4[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk("done8 timeout", {31'd0, done8}, 32'd1);
    endtask

    task automatic wait_done4();
        int n = 0;
        while (!done4 && n < 12) begin
            tick();
            n++;
        end
        chk("done4 timeout", {31'd0, done4}, 32'd1);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ed, input logic eb);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        q8.push_back({ed, eb});
        wait_done8();
        tick();
    endtask

    initial begin
        int cyc, n_done, last_done;
        logic prev;
        logic [3:0] x, y, dd;
        rst = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0;
        b8 = '0;
        a4 = '0;
        b4 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", {31'd0, busy8}, 32'd0);
        chk("reset done", {31'd0, done8}, 32'd0);
        chk("reset diff", {24'd0, diff8}, 32'd0);
        chk("reset borrow", {31'd0, borrow8}, 32'd0);

        // latency walk for 5 - 3
        a8 = 8'h05;
        b8 = 8'h03;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        q8.push_back({8'h02, 1'b0});
        chk("busy at E", {31'd0, busy8}, 32'd1);
        chk("done at E", {31'd0, done8}, 32'd0);
        repeat (7) tick();
        chk("done at E+7", {31'd0, done8}, 32'd0);
        chk("busy at E+7", {31'd0, busy8}, 32'd1);
        chk("borrow in RUN", {31'd0, borrow8}, 32'd0);
        tick();
        chk("done at E+8", {31'd0, done8}, 32'd1);
        tick();
        chk("done at E+9", {31'd0, done8}, 32'd0);
        chk("busy at E+9", {31'd0, busy8}, 32'd0);
        chk("diff held", {24'd0, diff8}, 32'h02);

        op8(8'h03, 8'h05, 8'hFE, 1'b1);
        op8(8'h00, 8'hFF, 8'h01, 1'b1);
        op8(8'hA5, 8'hA5, 8'h00, 1'b0);

        // start during RUN and DONE must be ignored
        a8 = 8'h10;
        b8 = 8'h01;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        q8.push_back({8'h0F, 1'b0});
        tick();
        tick();
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("start in DONE busy", {31'd0, busy8}, 32'd0);
        chk("start in DONE done", {31'd0, done8}, 32'd0);
        chk("start in DONE diff", {24'd0, diff8}, 32'h0F);
        tick();
        chk("idle after ignore", {31'd0, busy8}, 32'd0);

        // abort one edge after bit 4
        a8 = 8'h33;
        b8 = 8'h11;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", {31'd0, busy8}, 32'd0);
        chk("abort done", {31'd0, done8}, 32'd0);
        chk("abort diff", {24'd0, diff8}, 32'd0);
        chk("abort borrow", {31'd0, borrow8}, 32'd0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0);

        // start held high: three back-to-back operations
        a8 = 8'h09;
        b8 = 8'h04;
        repeat (3) q8.push_back({8'h05, 1'b0});
        start8 = 1'b1;
        cyc = 0;
        n_done = 0;
        last_done = 0;
        prev = 1'b0;
        while (n_done < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (done8) begin
                chk("done single cycle", {31'd0, prev}, 32'd0);
                if (n_done > 0) chk("done spacing", cyc - last_done, 32'd10);
                last_done = cyc;
                n_done++;
            end
            prev = done8;
        end
        start8 = 1'b0;
        chk("held start count", n_done, 32'd3);
        tick();
        chk("held start end done", {31'd0, done8}, 32'd0);
        chk("held start end busy", {31'd0, busy8}, 32'd0);

        // exhaustive WIDTH=4 sweep
        for (int i = 0; i < 256; i++) begin
            x = 4'(i >> 4);
            y = 4'(i);
            dd = x - y;
            a4 = x;
            b4 = y;
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            q4.push_back({dd, x < y});
            wait_done4();
            tick();
        end

        tick();
        chk("q8 drained", q8.size(), 32'd0);
        chk("q4 drained", q4.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor: the reverse-direction companion to the combinational half adder in the arithmetic building-block set. It computes `a - b` one bit per clock, LSB first, through a single registered borrow flip-flop. It uses a start/busy/done handshake, so it can sit behind a slow controller where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepting edge only
- b  input  WIDTH  subtrahend; captured on the accepting edge only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  (a - b) mod 2^WIDTH; held until next accept or reset
- borrow  output  1  final borrow, 1 iff a < b unsigned; held like diff

## Operation
- States are IDLE, RUN and DONE.
- **IDLE → RUN:** on an edge with start=1.
  - a and b are loaded into shift registers sa and sb.
  - The borrow flop br is cleared, the bit counter is cleared, and diff is cleared.
- **RUN, each edge:**
  - Bit d = sa[0] ^ sb[0] ^ br.
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sa and sb shift right by 1.
  - d shifts into diff[WIDTH-1], and diff shifts right.
  - The counter increments.
- **RUN → DONE:** on the edge that processes bit WIDTH-1. diff and borrow are then final.
- **DONE → IDLE:** unconditionally on the next edge.
- start is ignored in RUN and DONE, including a start held high across DONE. A start still high in IDLE after DONE is accepted as a new operation.
- a and b may change freely after the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH. No signed interpretation and no overflow flag.

## Timing
- **Reset:** rst=1 at an edge forces IDLE, busy=0, done=0, diff=0, borrow=0, br=0 and counter=0.
  - Reset overrides start.
  - Reset mid-RUN or in DONE aborts the operation and discards the partial result.
- **Latency:**
  - Operands are accepted at edge E.
  - busy=1 from E.
  - Bits 0..WIDTH-1 are processed at edges E+1..E+WIDTH.
  - done=1 and results are valid after edge E+WIDTH.
  - done=0 and busy=0 after edge E+WIDTH+1.
- **Throughput:** one operation per WIDTH+2 cycles when start is held high.
- **borrow:** updates only at the DONE transition. It reads 0 during RUN.
- **Counter:** $clog2(WIDTH) bits; it compares against WIDTH-1 and never wraps inside RUN.

## Structure
- Package serial_sub_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a localparam helper for counter width, $clog2(WIDTH).
- One sub-module, full_sub: combinational cell with inputs x, y, bin and outputs d, bout, using the equations above.
  - Instantiated once in serial_sub's datapath.
  - Unit-testable exhaustively (8 cases).
- All state, shift, counter and borrow registers live in serial_sub.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start pulsed at edge E:
  - busy=1 from E;
  - done=1 exactly in the cycle after E+8;
  - diff=0x02, borrow=0;
  - busy=0 after E+9.
- a=0x03, b=0x05 → diff=0xFE, borrow=1. a=0x00, b=0xFF → diff=0x01, borrow=1. a=b=0xA5 → diff=0x00, borrow=0.
- Accept a=0x10, b=0x01. Then pulse start with a=0xFF, b=0xFF during RUN and during DONE → both ignored; result is diff=0x0F, borrow=0.
- Assert rst one edge after bit 4 is processed → after that edge busy=0, done=0, diff=0x00, borrow=0. A following start with a=0x80, b=0x01 → diff=0x7F, borrow=0.
- start held high continuously for 3 operations → done pulses exactly WIDTH+2 cycles apart, each single-cycle.
- WIDTH=4, loop i=0..255 with {a,b}=i, one operation each → every diff equals (a-b)&0xF, and borrow equals (a<b).
